hdc_fold_scheduler: RTL
=======================

# hdc_fold_scheduler

Sequencing controller for the folded HDC sensor-fusion datapath. It accepts one feature vector per inference and maintains the 3-entry sliding window that the encoder consumes. It then steps the shared encoder through all `NUM_FOLDS` folds, triggers the associative-memory classifier, and returns valence/arousal on a valid/ready handshake. It sits between the feature source and the folded encoder/AM datapath, replacing window assembly and fold sequencing done outside the datapath.

## Interface
- `NUM_FOLDS`, 20: folds per inference; must divide `HV_DIMENSION` (2000).
- `FOLD_IDX_WIDTH`, `ceilLog2(NUM_FOLDS)`: width of `fold_idx`.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `features` input `TOTAL_NUM_CHANNEL*CHANNEL_WIDTH`: newest feature vector.
- `fin_valid` input 1 / `fin_ready` output 1: input handshake.
- `features_window` output `3*TOTAL_NUM_CHANNEL*CHANNEL_WIDTH`: `{cur, prev1, prev2}` to the encoder; stable from accept to the next accept.
- `fold_start` output 1: one-cycle pulse that starts fold `fold_idx`.
- `fold_idx` output `FOLD_IDX_WIDTH`: current fold.
- `fold_last` output 1: high while `fold_idx == NUM_FOLDS-1`.
- `fold_done` input 1: the datapath finished the current fold.
- `am_start` output 1: one-cycle pulse that starts classification.
- `am_done` input 1, `am_valence` input 1, `am_arousal` input 1: classifier result, valid with `am_done`.
- `valence` output 1, `arousal` output 1, `dout_valid` output 1 / `dout_ready` input 1: output handshake.
- `perf_latency` output 16: present only with `HDC_PERF_CNT_EN`.

## Operation
- States are IDLE, FOLD_ISSUE, FOLD_WAIT, AM_ISSUE, AM_WAIT and OUT.
- **IDLE:** `fin_ready=1`. When `fin_valid && fin_ready`:
  - the window shifts: `prev2<=prev1`, `prev1<=cur`, `cur<=features`;
  - `fold_idx<=0`;
  - the state moves to FOLD_ISSUE.
- **FOLD_ISSUE:** `fold_start=1` for one cycle, then FOLD_WAIT.
- **FOLD_WAIT:** waits for `fold_done`.
  - If `fold_idx==NUM_FOLDS-1`, go to AM_ISSUE.
  - Otherwise increment `fold_idx` and go to FOLD_ISSUE.
- **AM_ISSUE:** `am_start=1` for one cycle, then AM_WAIT.
- **AM_WAIT:** on `am_done`, register `am_valence`/`am_arousal` into `valence`/`arousal`, then go to OUT.
- **OUT:** `dout_valid=1`. `valence`/`arousal` are held until `dout_valid && dout_ready`, then the state returns to IDLE.
- **Ignored inputs:**
  - `fold_done` outside FOLD_WAIT;
  - `am_done` outside AM_WAIT;
  - `fin_valid` outside IDLE.
- **Window warm-up:** the history is zero after reset. The first inference sees `{f0,0,0}` and the second sees `{f1,f0,0}`.

## Timing
- **Reset values:**
  - state IDLE, `fin_ready=1`;
  - `features_window=0`, `fold_idx=0`, `fold_last=0`;
  - `fold_start=0`, `am_start=0`;
  - `dout_valid=0`, `valence=0`, `arousal=0`, `perf_latency=0`.
- **Reset mid-operation:** the in-flight inference is discarded, the window history is cleared, and all outputs take their reset values the cycle after `rst`.
- **Accept to first fold:** accept at edge T gives `fold_start` during cycle T+1 with `fold_idx=0`.
- **Fold pacing:** `fold_done` is sampled no earlier than the cycle after `fold_start`, so each fold takes at least 2 cycles.
- **Minimum latency:** with `fold_done`/`am_done` one cycle after each start, `dout_valid` rises at T+2·NUM_FOLDS+3 (43 cycles at the default).
- **Output handshake:** the handshake completes at edge E. `fin_ready` is 1 in cycle E+1, with no combinational ready-to-ready path.
- **Output stability:** `dout_valid` never drops without a handshake, and `valence`/`arousal` do not change while it is high.

## Configuration
- **`HDC_PERF_CNT_EN` defined:**
  - a 16-bit counter clears on fin accept and increments every cycle until the dout handshake, saturating at 0xFFFF;
  - on the handshake its value is latched into `perf_latency`, which holds until the next handshake.
- **Undefined:** the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package `hdc_ctrl_pkg` holds:
  - the state enum `hdc_sched_state_t`;
  - `FEATURE_WIDTH = TOTAL_NUM_CHANNEL*CHANNEL_WIDTH`;
  - `WINDOW_DEPTH = 3`.
- Sub-module `hdc_feature_window`: the 3-deep shift register with synchronous clear and a load-enable, driven by the fin handshake.
- The FSM and fold counter live in `hdc_fold_scheduler`.

## Test plan
- **Reset then idle:** hold `rst` for 5 cycles → every output at its reset value, `fin_ready=1`.
- **Single inference with 1-cycle datapath responders:**
  - drive `features=A`, `dout_ready=1`;
  - → 20 `fold_start` pulses with `fold_idx` 0..19, `fold_last` only at 19;
  - → one `am_start`;
  - → `dout_valid` 43 cycles after accept, carrying the responder's labels.
- **Window sequence A, B, C:** → `features_window` equals `{A,0,0}`, then `{B,A,0}`, then `{C,B,A}`.
- **Backpressure and stray inputs:**
  - hold `dout_ready=0` for 10 cycles → `dout_valid` and labels stable, `fin_ready=0`, extra `fin_valid` ignored;
  - inject stray `fold_done`/`am_done` in IDLE → no state change.
- **Reset at fold 7 of an inference:** → outputs reset next cycle; the following inference shows window `{X,0,0}` and `fold_idx` restarts at 0.
- **With `HDC_PERF_CNT_EN`:** repeat the single-inference case with 1-cycle responders → `perf_latency` equals the measured accept-to-handshake cycle count (43 with immediate `dout_ready`).

Source files
------------

// File: rtl/hdc_ctrl_pkg.sv
// ============================================================================
// Module  : hdc_ctrl_pkg
// Brief   : Shared types and sizes for the folded HDC fusion controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hdc_ctrl_pkg;

    localparam int TOTAL_NUM_CHANNEL = 4;
    localparam int CHANNEL_WIDTH     = 8;
    localparam int FEATURE_WIDTH     = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH;
    localparam int WINDOW_DEPTH      = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FOLD_ISSUE = 3'd1,
        FOLD_WAIT  = 3'd2,
        AM_ISSUE   = 3'd3,
        AM_WAIT    = 3'd4,
        OUT        = 3'd5
    } hdc_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/hdc_fold_scheduler_if.sv
// ============================================================================
// Module  : hdc_fold_scheduler_if
// Brief   : Feature-in, fold/AM control and label-out bundle of the scheduler.
//           perf_latency exists only when HDC_PERF_CNT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hdc_fold_scheduler_if #(
    parameter int NUM_FOLDS      = 20,
    parameter int FOLD_IDX_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
);
    import hdc_ctrl_pkg::*;

    logic [FEATURE_WIDTH-1:0]              features;
    logic                                  fin_valid;
    logic                                  fin_ready;
    logic [WINDOW_DEPTH*FEATURE_WIDTH-1:0] features_window;
    logic                                  fold_start;
    logic [FOLD_IDX_WIDTH-1:0]             fold_idx;
    logic                                  fold_last;
    logic                                  fold_done;
    logic                                  am_start;
    logic                                  am_done;
    logic                                  am_valence;
    logic                                  am_arousal;
    logic                                  valence;
    logic                                  arousal;
    logic                                  dout_valid;
    logic                                  dout_ready;
`ifdef HDC_PERF_CNT_EN
    logic [15:0]                           perf_latency;
`endif

    // master = scheduler, slave = feature source plus datapath plus sink
    modport master (
`ifdef HDC_PERF_CNT_EN
        output perf_latency,
`endif
        input  features, fin_valid, fold_done, am_done, am_valence, am_arousal, dout_ready,
        output fin_ready, features_window, fold_start, fold_idx, fold_last, am_start,
        output valence, arousal, dout_valid
    );

    modport slave (
`ifdef HDC_PERF_CNT_EN
        input  perf_latency,
`endif
        output features, fin_valid, fold_done, am_done, am_valence, am_arousal, dout_ready,
        input  fin_ready, features_window, fold_start, fold_idx, fold_last, am_start,
        input  valence, arousal, dout_valid
    );

endinterface

`default_nettype wire

// File: rtl/hdc_feature_window.sv
// ============================================================================
// Module  : hdc_feature_window
// Brief   : 3-deep feature history {cur, prev1, prev2}, cur in the MSBs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hdc_feature_window
    import hdc_ctrl_pkg::*;
(
    input  wire logic                                  clk,
    input  wire logic                                  rst,
    input  wire logic                                  load,
    input  wire logic [FEATURE_WIDTH-1:0]              din,
    output logic      [WINDOW_DEPTH*FEATURE_WIDTH-1:0] window
);

    logic [WINDOW_DEPTH*FEATURE_WIDTH-1:0] r_window;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= '0;
        end else if (load) begin
            r_window <= {din, r_window[WINDOW_DEPTH*FEATURE_WIDTH-1:FEATURE_WIDTH]};
        end
    end

    assign window = r_window;

endmodule

`default_nettype wire

// File: rtl/hdc_fold_scheduler.sv
// ============================================================================
// Module  : hdc_fold_scheduler
// Brief   : Window assembly, fold sequencing and AM trigger for the folded HDC
//           datapath. Optional HDC_PERF_CNT_EN adds an accept-to-output counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hdc_fold_scheduler
    import hdc_ctrl_pkg::*;
#(
    parameter int NUM_FOLDS      = 20,
    parameter int FOLD_IDX_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
    input wire logic              clk,
    input wire logic              rst,
    hdc_fold_scheduler_if.master  bus
);

    localparam logic [FOLD_IDX_WIDTH-1:0] C_LAST_FOLD = FOLD_IDX_WIDTH'(NUM_FOLDS - 1);

    hdc_sched_state_t          r_state;
    hdc_sched_state_t          w_state_next;
    logic [FOLD_IDX_WIDTH-1:0] r_fold_idx;
    logic                      r_valence;
    logic                      r_arousal;
    logic                      w_fin_ready;
    logic                      w_fold_start;
    logic                      w_am_start;
    logic                      w_dout_valid;
    logic                      w_accept;
    logic                      w_handshake;
    logic                      w_fold_last;

    assign w_accept    = w_fin_ready && bus.fin_valid;
    assign w_handshake = w_dout_valid && bus.dout_ready;
    assign w_fold_last = (r_fold_idx == C_LAST_FOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (bus.fin_valid) w_state_next = FOLD_ISSUE;
            FOLD_ISSUE: w_state_next = FOLD_WAIT;
            FOLD_WAIT:  if (bus.fold_done) w_state_next = w_fold_last ? AM_ISSUE : FOLD_ISSUE;
            AM_ISSUE:   w_state_next = AM_WAIT;
            AM_WAIT:    if (bus.am_done) w_state_next = OUT;
            OUT:        if (bus.dout_ready) w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Moore outputs: ready/valid never depend combinationally on the other side
    always_comb begin
        w_fin_ready  = 1'b0;
        w_fold_start = 1'b0;
        w_am_start   = 1'b0;
        w_dout_valid = 1'b0;
        case (r_state)
            IDLE:       w_fin_ready  = 1'b1;
            FOLD_ISSUE: w_fold_start = 1'b1;
            AM_ISSUE:   w_am_start   = 1'b1;
            OUT:        w_dout_valid = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fold_idx <= '0;
            r_valence  <= 1'b0;
            r_arousal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fold_idx <= '0;
            end else if (r_state == FOLD_WAIT && bus.fold_done && !w_fold_last) begin
                r_fold_idx <= r_fold_idx + FOLD_IDX_WIDTH'(1);
            end
            if (r_state == AM_WAIT && bus.am_done) begin
                r_valence <= bus.am_valence;
                r_arousal <= bus.am_arousal;
            end
        end
    end

    hdc_feature_window u_window (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .din    (bus.features),
        .window (bus.features_window)
    );

`ifdef HDC_PERF_CNT_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_perf_latency;
    logic [15:0] w_perf_next;

    // Latch the incremented value so the handshake cycle itself is counted
    assign w_perf_next = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt     <= '0;
            r_perf_latency <= '0;
        end else begin
            if (w_accept) begin
                r_perf_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_perf_cnt <= w_perf_next;
            end
            if (w_handshake) begin
                r_perf_latency <= w_perf_next;
            end
        end
    end

    assign bus.perf_latency = r_perf_latency;
`endif

    assign bus.fin_ready  = w_fin_ready;
    assign bus.fold_start = w_fold_start;
    assign bus.am_start   = w_am_start;
    assign bus.dout_valid = w_dout_valid;
    assign bus.fold_idx   = r_fold_idx;
    assign bus.fold_last  = w_fold_last;
    assign bus.valence    = r_valence;
    assign bus.arousal    = r_arousal;

endmodule

`default_nettype wire
